// File: rtl/bcd_time_pkg.sv
// Shared constants, preset payload layout and hour-range helpers for the
// BCD time-of-day / stopwatch counter.
package bcd_time_pkg;

    localparam int unsigned DIG_MAX   = 9;
    localparam int unsigned TENS_MAX  = 5;
    localparam int unsigned UNITS_W   = 4;
    localparam int unsigned TENS_W    = 3;
    localparam int unsigned HR_TENS_W = 2;

    // Preset layout, MSB first: hours, minutes, seconds, tenths, hundredths
    typedef struct packed {
        logic [HR_TENS_W-1:0] dh;
        logic [UNITS_W-1:0]   uh;
        logic [TENS_W-1:0]    dm;
        logic [UNITS_W-1:0]   um;
        logic [TENS_W-1:0]    ds;
        logic [UNITS_W-1:0]   us;
        logic [UNITS_W-1:0]   dec;
        logic [UNITS_W-1:0]   cen;
    } bcd_time_t;

    function automatic logic hour_wrap_legal(input int unsigned hw);
        return (hw == 32'd24) || (hw == 32'd12);
    endfunction

    function automatic logic hour_ok(input logic [HR_TENS_W-1:0] t,
                                     input logic [UNITS_W-1:0]   u,
                                     input int unsigned          hw);
        return (u <= 4'd9) && ((32'(t) * 32'd10 + 32'(u)) < hw);
    endfunction

endpackage

// File: rtl/bcd_time_clock_if.sv
// Control strobes, preset payload and BCD digit/event outputs of bcd_time_clock.
interface bcd_time_clock_if;
    import bcd_time_pkg::*;

    logic      tick;
    logic      stay;
    logic      down;
    logic      load;
    bcd_time_t preset;
    logic      add;
    logic      add_sel;

    logic [3:0] centesimas;
    logic [3:0] decimas;
    logic [3:0] unidadesSegundo;
    logic [2:0] decenasSegundo;
    logic [3:0] unidadesMinuto;
    logic [2:0] decenasMinuto;
    logic [3:0] unidadesHora;
    logic [1:0] decenasHora;
    logic       day_wrap;
    logic       expired;
    logic       is_zero;

    modport master (
        output tick, stay, down, load, preset, add, add_sel,
        input  centesimas, decimas, unidadesSegundo, decenasSegundo,
               unidadesMinuto, decenasMinuto, unidadesHora, decenasHora,
               day_wrap, expired, is_zero
    );

    modport slave (
        input  tick, stay, down, load, preset, add, add_sel,
        output centesimas, decimas, unidadesSegundo, decenasSegundo,
               unidadesMinuto, decenasMinuto, unidadesHora, decenasHora,
               day_wrap, expired, is_zero
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register with wrap-around increment/decrement, clear and
// range-checked load. Priority: rst > clr > ld > inc > dec.
module bcd_digit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX);

    logic [WIDTH-1:0] q_nxt;

    assign at_max  = (q == QMAX);
    assign at_zero = (q == '0);

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (ld) begin
            q_nxt = (ld_val > QMAX) ? '0 : ld_val;
        end else if (inc) begin
            q_nxt = at_max ? '0 : q + WIDTH'(1);
        end else if (dec) begin
            q_nxt = at_zero ? QMAX : q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/bcd_time_clock.sv
// BCD HH:MM:SS.ff time-of-day / stopwatch / timer counter owning the whole
// carry/borrow chain, with preset load, manual setting and event pulses.
module bcd_time_clock
    import bcd_time_pkg::*;
#(
    parameter int unsigned HOUR_WRAP   = 24,
    parameter int unsigned FRAC_DIGITS = 2,
    parameter int unsigned DOWN_EN     = 1
) (
    input logic             clk,
    input logic             rst,
    bcd_time_clock_if.slave bus
);

    localparam int unsigned HW        = hour_wrap_legal(HOUR_WRAP) ? HOUR_WRAP : 24;
    localparam int unsigned HR_T_MAX  = (HW - 1) / 10;
    localparam int unsigned HR_U_LAST = (HW - 1) % 10;
    localparam int unsigned LSB       = (FRAC_DIGITS >= 2) ? 0 : 2 - FRAC_DIGITS;
    localparam logic [7:0]  LSB_MASK  = 8'(1 << LSB);

    // Digit index: 0 cen, 1 dec, 2 us, 3 ds, 4 um, 5 dm, 6 uh, 7 dh
    logic [3:0] q_cen, q_dec, q_us, q_um, q_uh;
    logic [2:0] q_ds, q_dm;
    logic [1:0] q_dh;

    logic [7:0] inc, dec, clr;
    logic [7:0] at_max, at_zero, lo_zero;
    logic [6:0] lo_max;
    logic       mx_run, zr_run;

    logic      dir_dn, cnt, cnt_up, cnt_dn;
    logic      add_en, add_min, add_hr;
    logic      hr_last, hr_step, all_zero, lsb_one;
    logic      wrap_c, expire_c, zero_n;
    logic      day_wrap_q, expired_q, is_zero_q;
    bcd_time_t ld_v;

    // Strobe qualification: load beats add, add only while stopped
    assign dir_dn  = bus.down & (DOWN_EN != 0);
    assign cnt     = bus.tick & bus.stay & ~bus.load;
    assign cnt_up  = cnt & ~dir_dn;
    assign cnt_dn  = cnt & dir_dn;
    assign add_en  = bus.add & ~bus.stay & ~bus.load;
    assign add_min = add_en & ~bus.add_sel;
    assign add_hr  = add_en & bus.add_sel;

    assign all_zero = &at_zero;
    assign hr_last  = at_max[7] & (q_uh == 4'(HR_U_LAST));
    assign hr_step  = (cnt_up & lo_max[6]) | add_hr;

    // Per-field range check of the preset; bad hours load as 00
    always_comb begin
        ld_v = bus.preset;
        if (ld_v.cen > 4'(DIG_MAX))  ld_v.cen = '0;
        if (ld_v.dec > 4'(DIG_MAX))  ld_v.dec = '0;
        if (ld_v.us  > 4'(DIG_MAX))  ld_v.us  = '0;
        if (ld_v.ds  > 3'(TENS_MAX)) ld_v.ds  = '0;
        if (ld_v.um  > 4'(DIG_MAX))  ld_v.um  = '0;
        if (ld_v.dm  > 3'(TENS_MAX)) ld_v.dm  = '0;
        if (!hour_ok(bus.preset.dh, bus.preset.uh, HW)) begin
            ld_v.dh = '0;
            ld_v.uh = '0;
        end
        if (FRAC_DIGITS < 2) ld_v.cen = '0;
        if (FRAC_DIGITS < 1) ld_v.dec = '0;
    end

    // lo_max[k]/lo_zero[k]: every digit below k sits at its max / at zero
    always_comb begin
        mx_run  = 1'b1;
        zr_run  = 1'b1;
        lo_max  = '0;
        lo_zero = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                lo_max[k] = mx_run;
                mx_run    = mx_run & at_max[k];
            end
            lo_zero[k] = zr_run;
            zr_run     = zr_run & at_zero[k];
        end
    end

    // Carry/borrow chain and manual-set steering
    always_comb begin
        inc = '0;
        dec = '0;
        clr = '0;
        for (int k = 0; k < 8; k++) begin
            dec[k] = cnt_dn & ~all_zero & lo_zero[k];
        end
        for (int k = 0; k < 6; k++) begin
            inc[k] = cnt_up & lo_max[k];
        end
        inc[4]   = inc[4] | add_min;
        inc[5]   = inc[5] | (add_min & at_max[4]);
        clr[3:0] = {4{add_en}};
        inc[6]   = hr_step;
        inc[7]   = hr_step & at_max[6];
        clr[7:6] = {2{hr_step & hr_last}};
    end

    always_comb begin
        case (LSB)
            0:       lsb_one = (q_cen == 4'd1);
            1:       lsb_one = (q_dec == 4'd1);
            default: lsb_one = (q_us == 4'd1);
        endcase
    end

    assign wrap_c   = cnt_up & lo_max[6] & hr_last;
    assign expire_c = cnt_dn & lsb_one & (&(at_zero | LSB_MASK));

    // Value of is_zero after this edge, derived from the operation taking place
    always_comb begin
        zero_n = is_zero_q;
        if (bus.load) begin
            zero_n = (ld_v == '0);
        end else if (add_min) begin
            zero_n = at_max[4] & at_max[5] & at_zero[6] & at_zero[7];
        end else if (add_hr) begin
            zero_n = hr_last & at_zero[4] & at_zero[5];
        end else if (cnt_up) begin
            zero_n = wrap_c;
        end else if (cnt_dn) begin
            zero_n = all_zero | expire_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            day_wrap_q <= 1'b0;
            expired_q  <= 1'b0;
            is_zero_q  <= 1'b1;
        end else begin
            day_wrap_q <= wrap_c;
            expired_q  <= expire_c;
            is_zero_q  <= zero_n;
        end
    end

    if (FRAC_DIGITS >= 2) begin : g_cen
        bcd_digit #(.WIDTH(UNITS_W), .MAX(DIG_MAX)) u_cen (
            .clk, .rst, .inc(inc[0]), .dec(dec[0]), .clr(clr[0]), .ld(bus.load),
            .ld_val(ld_v.cen), .q(q_cen), .at_max(at_max[0]), .at_zero(at_zero[0]));
    end else begin : g_no_cen
        assign q_cen      = '0;
        assign at_max[0]  = 1'b1;
        assign at_zero[0] = 1'b1;
    end

    if (FRAC_DIGITS >= 1) begin : g_dec
        bcd_digit #(.WIDTH(UNITS_W), .MAX(DIG_MAX)) u_dec (
            .clk, .rst, .inc(inc[1]), .dec(dec[1]), .clr(clr[1]), .ld(bus.load),
            .ld_val(ld_v.dec), .q(q_dec), .at_max(at_max[1]), .at_zero(at_zero[1]));
    end else begin : g_no_dec
        assign q_dec      = '0;
        assign at_max[1]  = 1'b1;
        assign at_zero[1] = 1'b1;
    end

    bcd_digit #(.WIDTH(UNITS_W), .MAX(DIG_MAX)) u_us (
        .clk, .rst, .inc(inc[2]), .dec(dec[2]), .clr(clr[2]), .ld(bus.load),
        .ld_val(ld_v.us), .q(q_us), .at_max(at_max[2]), .at_zero(at_zero[2]));

    bcd_digit #(.WIDTH(TENS_W), .MAX(TENS_MAX)) u_ds (
        .clk, .rst, .inc(inc[3]), .dec(dec[3]), .clr(clr[3]), .ld(bus.load),
        .ld_val(ld_v.ds), .q(q_ds), .at_max(at_max[3]), .at_zero(at_zero[3]));

    bcd_digit #(.WIDTH(UNITS_W), .MAX(DIG_MAX)) u_um (
        .clk, .rst, .inc(inc[4]), .dec(dec[4]), .clr(clr[4]), .ld(bus.load),
        .ld_val(ld_v.um), .q(q_um), .at_max(at_max[4]), .at_zero(at_zero[4]));

    bcd_digit #(.WIDTH(TENS_W), .MAX(TENS_MAX)) u_dm (
        .clk, .rst, .inc(inc[5]), .dec(dec[5]), .clr(clr[5]), .ld(bus.load),
        .ld_val(ld_v.dm), .q(q_dm), .at_max(at_max[5]), .at_zero(at_zero[5]));

    // Hour units: generic 0..9 digit; the HW-1 -> 00 wrap is forced via clr
    bcd_digit #(.WIDTH(UNITS_W), .MAX(DIG_MAX)) u_uh (
        .clk, .rst, .inc(inc[6]), .dec(dec[6]), .clr(clr[6]), .ld(bus.load),
        .ld_val(ld_v.uh), .q(q_uh), .at_max(at_max[6]), .at_zero(at_zero[6]));

    bcd_digit #(.WIDTH(HR_TENS_W), .MAX(HR_T_MAX)) u_dh (
        .clk, .rst, .inc(inc[7]), .dec(dec[7]), .clr(clr[7]), .ld(bus.load),
        .ld_val(ld_v.dh), .q(q_dh), .at_max(at_max[7]), .at_zero(at_zero[7]));

    assign bus.centesimas      = q_cen;
    assign bus.decimas         = q_dec;
    assign bus.unidadesSegundo = q_us;
    assign bus.decenasSegundo  = q_ds;
    assign bus.unidadesMinuto  = q_um;
    assign bus.decenasMinuto   = q_dm;
    assign bus.unidadesHora    = q_uh;
    assign bus.decenasHora     = q_dh;
    assign bus.day_wrap        = day_wrap_q;
    assign bus.expired         = expired_q;
    assign bus.is_zero         = is_zero_q;

endmodule

// File: tb/tb_bcd_time_clock.sv
// Scoreboard bench for bcd_time_clock: 24h and 12h instances share stimulus and
// are checked against a centisecond-count reference model.
module tb_bcd_time_clock;
    import bcd_time_pkg::*;

    bit   clk;
    logic rst;

    bcd_time_clock_if bus24 ();
    bcd_time_clock_if bus12 ();

    bcd_time_clock #(.HOUR_WRAP(24), .FRAC_DIGITS(2), .DOWN_EN(1)) dut24 (
        .clk(clk), .rst(rst), .bus(bus24));
    bcd_time_clock #(.HOUR_WRAP(12), .FRAC_DIGITS(2), .DOWN_EN(1)) dut12 (
        .clk(clk), .rst(rst), .bus(bus12));

    assign bus12.tick    = bus24.tick;
    assign bus12.stay    = bus24.stay;
    assign bus12.down    = bus24.down;
    assign bus12.load    = bus24.load;
    assign bus12.preset  = bus24.preset;
    assign bus12.add     = bus24.add;
    assign bus12.add_sel = bus24.add_sel;

    always #5 clk = ~clk;

    logic [30:0] a24, a12;
    assign a24 = {bus24.decenasHora, bus24.unidadesHora, bus24.decenasMinuto, bus24.unidadesMinuto,
                  bus24.decenasSegundo, bus24.unidadesSegundo, bus24.decimas, bus24.centesimas,
                  bus24.day_wrap, bus24.expired, bus24.is_zero};
    assign a12 = {bus12.decenasHora, bus12.unidadesHora, bus12.decenasMinuto, bus12.unidadesMinuto,
                  bus12.decenasSegundo, bus12.unidadesSegundo, bus12.decimas, bus12.centesimas,
                  bus12.day_wrap, bus12.expired, bus12.is_zero};

    typedef struct {
        logic [30:0] e24;
        logic [30:0] e12;
        int unsigned id;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned step_no = 0;
    int unsigned t_m[2] = '{0, 0};

    function automatic logic [27:0] pk(input int unsigned h, input int unsigned m,
                                       input int unsigned s, input int unsigned f);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10), 4'(f / 10), 4'(f % 10)};
    endfunction

    function automatic logic [27:0] pkr(input int unsigned dh, input int unsigned uh,
                                        input int unsigned dm, input int unsigned um,
                                        input int unsigned ds, input int unsigned us,
                                        input int unsigned de, input int unsigned ce);
        return {2'(dh), 4'(uh), 3'(dm), 4'(um), 3'(ds), 4'(us), 4'(de), 4'(ce)};
    endfunction

    function automatic logic [30:0] to_vec(input int unsigned t, input bit dw, input bit ex);
        int unsigned f = t % 100;
        int unsigned s = (t / 100) % 60;
        int unsigned m = (t / 6000) % 60;
        int unsigned h = t / 360000;
        bit          z = (t == 0);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10), 4'(f / 10), 4'(f % 10), dw, ex, z};
    endfunction

    // Preset -> centiseconds, out-of-range fields reading as zero
    function automatic int unsigned load_t(input logic [27:0] p, input int unsigned hw);
        int unsigned dh = 32'(p[27:26]);
        int unsigned uh = 32'(p[25:22]);
        int unsigned dm = 32'(p[21:19]);
        int unsigned um = 32'(p[18:15]);
        int unsigned ds = 32'(p[14:12]);
        int unsigned us = 32'(p[11:8]);
        int unsigned de = 32'(p[7:4]);
        int unsigned ce = 32'(p[3:0]);
        int unsigned h, m, s, f;
        h = (uh > 9 || dh * 10 + uh >= hw) ? 0 : dh * 10 + uh;
        m = (dm > 5 ? 0 : dm) * 10 + (um > 9 ? 0 : um);
        s = (ds > 5 ? 0 : ds) * 10 + (us > 9 ? 0 : us);
        f = (de > 9 ? 0 : de) * 10 + (ce > 9 ? 0 : ce);
        return ((h * 60 + m) * 60 + s) * 100 + f;
    endfunction

    function automatic void check(input string nm, input int unsigned id,
                                  input logic [30:0] act, input logic [30:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d: got digits %07h flags(wrap,exp,zero) %03b, want digits %07h flags %03b",
                     nm, id, act[30:3], act[2:0], want[30:3], want[2:0]);
        end
    endfunction

    task automatic step(input bit r, input bit ld, input logic [27:0] p, input bit ad,
                        input bit sel, input bit tk, input bit st, input bit dn);
        exp_t        e;
        int unsigned hw, t, h, m;
        bit          dw, ex;
        rst           = r;
        bus24.load    = ld;
        bus24.preset  = p;
        bus24.add     = ad;
        bus24.add_sel = sel;
        bus24.tick    = tk;
        bus24.stay    = st;
        bus24.down    = dn;
        for (int i = 0; i < 2; i++) begin
            hw = (i == 0) ? 24 : 12;
            t  = t_m[i];
            dw = 1'b0;
            ex = 1'b0;
            if (r) begin
                t = 0;
            end else if (ld) begin
                t = load_t(p, hw);
            end else if (ad && !st) begin
                h = t / 360000;
                m = (t / 6000) % 60;
                if (sel) h = (h + 1) % hw;
                else     m = (m + 1) % 60;
                t = (h * 60 + m) * 6000;
            end else if (tk && st) begin
                if (!dn) begin
                    t  = (t + 1) % (hw * 360000);
                    dw = (t == 0);
                end else if (t != 0) begin
                    t  = t - 1;
                    ex = (t == 0);
                end
            end
            t_m[i] = t;
            if (i == 0) e.e24 = to_vec(t, dw, ex);
            else        e.e12 = to_vec(t, dw, ex);
        end
        e.id = step_no;
        step_no++;
        expq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry retires per clock, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("hw24", e.id, a24, e.e24);
            check("hw12", e.id, a12, e.e12);
        end
    end

    initial begin
        logic [27:0] p;
        int unsigned r;
        bit          dn;

        // reset and idle
        step(1, 0, '0, 0, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        // day rollover from 23:59:59.98 (12h instance loads 00:59:59.98)
        step(0, 1, pk(23, 59, 59, 98), 0, 0, 0, 1, 0);
        step(0, 0, '0, 0, 0, 1, 1, 0);
        step(0, 0, '0, 0, 0, 1, 1, 0);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        // 12h rollover from 11:59:59.99
        step(0, 1, pk(11, 59, 59, 99), 0, 0, 0, 1, 0);
        step(0, 0, '0, 0, 0, 1, 1, 0);
        step(0, 0, '0, 0, 0, 1, 1, 0);
        // timer down to zero, then saturate
        step(0, 1, pk(0, 0, 0, 2), 0, 0, 0, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        // borrow through hours, then direction change
        step(0, 1, pk(10, 0, 0, 0), 0, 0, 0, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        step(0, 0, '0, 0, 0, 1, 1, 0);
        step(0, 0, '0, 0, 0, 1, 1, 1);
        // out-of-range preset fields
        step(0, 1, pkr(2, 5, 7, 3, 4, 2, 1, 6), 0, 0, 0, 1, 0);
        step(0, 1, pkr(1, 9, 6, 0, 6, 10, 12, 3), 0, 0, 0, 1, 0);
        step(0, 1, pkr(3, 0, 5, 15, 5, 9, 9, 15), 0, 0, 0, 1, 0);
        // manual set while stopped; ignored while running
        step(0, 1, pk(12, 59, 30, 50), 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        step(0, 1, pk(23, 15, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 1, 0, 0, 0);
        step(0, 0, '0, 1, 1, 0, 0, 0);
        step(0, 1, pk(11, 59, 0, 0), 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 1, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 1, 0);
        step(0, 0, '0, 1, 1, 1, 1, 0);
        // stopped: ticks ignored
        step(0, 0, '0, 0, 0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1, 0, 1);
        // priorities
        step(1, 1, pk(5, 5, 5, 5), 0, 0, 1, 1, 0);
        step(0, 1, pk(5, 5, 5, 5), 0, 0, 1, 1, 0);
        step(0, 1, pk(1, 2, 3, 4), 1, 1, 0, 0, 0);
        step(0, 1, pk(0, 0, 0, 0), 0, 0, 1, 1, 1);

        // randomized traffic with boundary-biased presets
        dn = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) dn = ~dn;
            case ($urandom_range(0, 3))
                0:       p = 28'($urandom);
                1:       p = pk(23, 59, 59, $urandom_range(95, 99));
                2:       p = pk(0, 0, $urandom_range(0, 1), $urandom_range(0, 5));
                default: p = pk(11, 59, 59, $urandom_range(90, 99));
            endcase
            if (r < 2)       step(1, 0, p, 0, 0, 1, 1, dn);
            else if (r < 10) step(0, 1, p, 0, 0, $urandom_range(0, 1) == 1, 1, dn);
            else if (r < 15) step(0, 0, p, 1, $urandom_range(0, 1) == 1, 1,
                                  $urandom_range(0, 1) == 1, dn);
            else             step(0, 0, p, 0, 0, $urandom_range(0, 4) != 0,
                                  $urandom_range(0, 6) != 0, dn);
        end

        for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never checked, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_time_clock.md
# bcd_time_clock

Parametrised BCD time-of-day and stopwatch/timer counter. It produces the complete digit set HH:MM:SS plus 0–2 fractional digits as registered BCD outputs for the display multiplexer. It supersedes the per-digit counter modules: one block owns the whole carry chain. It adds count-down (timer) mode, preset load, 12/24-hour wrap, manual minute/hour setting, and event pulses.

## Interface
Parameters:
- `HOUR_WRAP`, default 24: hour modulus. Legal values are 24 and 12. Hours run 00..HOUR_WRAP-1.
- `FRAC_DIGITS`, default 2: number of sub-second digits (0, 1 or 2). Absent digits are tied to 0.
- `DOWN_EN`, default 1: when 0, the `down` input is ignored and the block counts up only.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: single-cycle count enable at 10^FRAC_DIGITS Hz.
- `stay` in 1: run enable. 1 = counting, 0 = stopped.
- `down` in 1: direction. 1 = count down (timer).
- `load` in 1: single-cycle preset strobe.
- `preset` in 28: load value, MSB first: decenasHora[1:0], unidadesHora[3:0], decenasMinuto[2:0], unidadesMinuto[3:0], decenasSegundo[2:0], unidadesSegundo[3:0], decimas[3:0], centesimas[3:0].
- `add` in 1: single-cycle manual-increment strobe.
- `add_sel` in 1: target field for `add`. 0 = minutes, 1 = hours.
- `centesimas` out 4, `decimas` out 4, `unidadesSegundo` out 4, `decenasSegundo` out 3, `unidadesMinuto` out 4, `decenasMinuto` out 3, `unidadesHora` out 4, `decenasHora` out 2: BCD digits.
- `day_wrap` out 1: one-cycle pulse on the up-count rollover to zero.
- `expired` out 1: one-cycle pulse when the down-count reaches zero.
- `is_zero` out 1: level, high while all digits are 0.

## Operation
- Priority per edge: `rst` > `load` > `add` (only when `stay`=0) > counting (`tick` & `stay`).
- Reset:
  - All digits become 0.
  - `day_wrap` = 0, `expired` = 0, `is_zero` = 1.
- Up count:
  - Each digit increments when every lower digit is at its maximum.
  - Digit maxima: fractional and units digits 9; decenasSegundo and decenasMinuto 5.
  - Hour field wraps HOUR_WRAP-1 → 0. For 24 that is 23 → 00 (unidadesHora wraps at 3 when decenasHora=2); for 12 it is 11 → 00.
  - The full rollover (HOUR_WRAP-1):59:59.99 → all zero asserts `day_wrap`.
- Down count (`down`=1, `DOWN_EN`=1):
  - Mirror borrow chain: a digit at 0 reloads its maximum when every lower digit is 0.
  - At all-zero the counter saturates and does not wrap; further ticks are ignored.
  - The transition into all-zero asserts `expired` once. Ticking while already zero produces no pulse.
  - Down-counting hours from 10 gives 09; hours never underflow because of saturation.
- Load:
  - Each preset field is range-checked against its maximum.
  - An out-of-range field loads 0, other fields load as given.
  - An hour value ≥ HOUR_WRAP loads 00.
  - Load never generates `day_wrap` or `expired`.
- Manual add:
  - Only when `stay`=0; ignored while running.
  - add_sel=0: minutes increment 59 → 00 with no carry into hours.
  - add_sel=1: hours increment modulo HOUR_WRAP.
  - Seconds and fractional digits are cleared on any add.
- `down` change mid-count takes effect on the next counting edge; no digit glitch.
- When `stay`=0, `tick` is ignored. Digits hold.

## Timing
- All outputs are registered. Digits update on the same edge that samples `tick`, `load` or `add` high.
- `day_wrap` and `expired` are high exactly one cycle: the cycle in which the digits show zero.
- `is_zero` is registered and coincident with the digit update.
- Latency is 1 clock from strobe to output. Back-to-back ticks on consecutive cycles are supported.

## Structure
- Package `bcd_time_pkg` holds:
  - digit maximum constants (9, 5);
  - the preset field offsets/widths;
  - the hour-wrap legality check.
- Sub-module `bcd_digit` (parameters WIDTH, MAX) provides:
  - inputs: `inc`, `dec`, `clr`, `ld`, `ld_val`;
  - outputs: `q`, `at_max`, `at_zero`.
- The top level instantiates 8 `bcd_digit`s (fractional digits generated per FRAC_DIGITS) plus hour-wrap logic and pulse registers.

## Test plan
- Reset, then preset 23:59:59.98, `stay`=1, two ticks → 23:59:59.99, then 00:00:00.00 with `day_wrap`=1 for one cycle.
- HOUR_WRAP=12: preset 11:59:59.99, one tick → 00:00:00.00 with `day_wrap` pulse.
- `down`=1: preset 00:00:00.02, three ticks → .01, then .00 with `expired`=1 once, then holds .00 with no pulse. Also preset 10:00:00.00, one tick → 09:59:59.99.
- Load preset with decenasMinuto=7 and hours=25 → minutes tens 0, hours 00; other fields as given.
- `stay`=0, add with add_sel=0 at 12:59:30.50 → 12:00:00.00 (hours unchanged). Then add with add_sel=1 at 23:xx → 00. The same add with `stay`=1 is ignored.
- Simultaneous `rst`, `load` and `tick` → all zero. `load` and `tick` together → preset value, not preset+1.
